// File: rtl/snoop_responder_pkg.sv
// Shared cache definitions: bus ops, snoop results, L1 messages, MESI and responder FSM states.
// Address split is offset [5:0], index [20:6], tag [31:21].
package cache_Defs;

  localparam int DEF_WAYS      = 8;
  localparam int DEF_NB_OFFSET = 6;
  localparam int DEF_NB_INDEX  = 15;
  localparam int DEF_NB_TAG    = 11;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_COMPARE, ST_RESULT, ST_GETL, ST_WB, ST_INVL, ST_UPDATE
  } snp_state_t;

  localparam logic [2:0] OP_READ       = 3'd1;
  localparam logic [2:0] OP_WRITE      = 3'd2;
  localparam logic [2:0] OP_INVALIDATE = 3'd3;
  localparam logic [2:0] OP_RWIM       = 3'd4;

  localparam logic [1:0] SNP_NOHIT = 2'd0;
  localparam logic [1:0] SNP_HIT   = 2'd1;
  localparam logic [1:0] SNP_HITM  = 2'd2;

  localparam logic [2:0] MSG_GETLINE        = 3'd2;
  localparam logic [2:0] MSG_INVALIDATELINE = 3'd3;

endpackage

// File: rtl/snoop_responder_way_match.sv
// Combinational tag/state compare across all ways of one set.
// A way hits when its tag matches and it is not Invalid; the lowest hitting way wins.
module snoop_way_match
  import cache_Defs::*;
#(
  parameter int WAYS   = DEF_WAYS,
  parameter int NB_TAG = DEF_NB_TAG,
  parameter int WAY_W  = $clog2(WAYS)
) (
  input  logic [NB_TAG-1:0]      tag,
  input  logic [WAYS*NB_TAG-1:0] tags,
  input  logic [WAYS*2-1:0]      mesi,
  output logic                   hit,
  output logic [WAYS-1:0]        hit_vec,
  output logic [WAY_W-1:0]       way,
  output logic                   multi_hit
);

  always_comb begin
    hit_vec = '0;
    way     = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = (tags[w*NB_TAG +: NB_TAG] == tag) && (mesi[w*2 +: 2] != MESI_I);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) way = WAY_W'(w);
    end
    hit       = |hit_vec;
    multi_hit = (hit_vec & (hit_vec - 1'b1)) != '0;
  end

endmodule

// File: rtl/snoop_responder.sv
// Snoop responder: accepts one bus op, looks it up in L2 tags, returns NOHIT/HIT/HITM,
// then sequences L1 message, write-back and MESI update. All outputs are registered.
module snoop_responder
  import cache_Defs::*;
#(
  parameter int WAYS      = DEF_WAYS,
  parameter int NB_OFFSET = DEF_NB_OFFSET,
  parameter int NB_INDEX  = DEF_NB_INDEX,
  parameter int NB_TAG    = DEF_NB_TAG,
  parameter int WAY_W     = $clog2(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   snoop_valid,
  output logic                   snoop_ready,
  input  logic [2:0]             snoop_op,
  input  logic [31:0]            snoop_addr,
  output logic                   lk_req,
  output logic [NB_INDEX-1:0]    lk_index,
  input  logic [WAYS*NB_TAG-1:0] lk_tags,
  input  logic [WAYS*2-1:0]      lk_mesi,
  output logic                   snp_result_valid,
  output logic [1:0]             snp_result,
  output logic                   st_we,
  output logic [NB_INDEX-1:0]    st_index,
  output logic [WAY_W-1:0]       st_way,
  output logic [1:0]             st_mesi,
  output logic                   l1_msg_valid,
  output logic [2:0]             l1_msg,
  output logic [31:0]            l1_msg_addr,
  input  logic                   l1_msg_ready,
  output logic                   wb_valid,
  output logic [31:0]            wb_addr,
  input  logic                   wb_ready,
  output logic                   protocol_err
);

  localparam int LINE_W = 32 - NB_OFFSET;

  snp_state_t state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [2:0] op_q, op_d;
  logic [WAY_W-1:0] way_q, way_d;
  mesi_t tgt_q, tgt_d;
  logic getl_q, getl_d, invl_q, invl_d, upd_q, upd_d;

  logic snoop_ready_q, snoop_ready_d, lk_req_q, lk_req_d;
  logic [NB_INDEX-1:0] lk_index_q, lk_index_d, st_index_q, st_index_d;
  logic snp_result_valid_q, snp_result_valid_d, protocol_err_q, protocol_err_d;
  logic [1:0] snp_result_q, snp_result_d, st_mesi_q, st_mesi_d;
  logic st_we_q, st_we_d, l1_msg_valid_q, l1_msg_valid_d, wb_valid_q, wb_valid_d;
  logic [WAY_W-1:0] st_way_q, st_way_d;
  logic [2:0] l1_msg_q, l1_msg_d;
  logic [31:0] l1_msg_addr_q, l1_msg_addr_d, wb_addr_q, wb_addr_d;

  logic m_hit, m_multi;
  logic [WAYS-1:0] m_vec;
  logic [WAY_W-1:0] m_way;
  mesi_t hmesi;
  logic [1:0] res_c;
  logic err_c;
  logic unused_offset;

  assign unused_offset = ^snoop_addr[NB_OFFSET-1:0];

  snoop_way_match #(.WAYS(WAYS), .NB_TAG(NB_TAG), .WAY_W(WAY_W)) u_match (
    .tag       (line_q[NB_INDEX +: NB_TAG]),
    .tags      (lk_tags),
    .mesi      (lk_mesi),
    .hit       (m_hit),
    .hit_vec   (m_vec),
    .way       (m_way),
    .multi_hit (m_multi)
  );

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    op_d    = op_q;
    way_d   = way_q;
    tgt_d   = tgt_q;
    getl_d  = getl_q;
    invl_d  = invl_q;
    upd_d   = upd_q;
    res_c   = SNP_NOHIT;
    err_c   = 1'b0;
    hmesi   = MESI_I;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (m_vec[w]) hmesi = mesi_t'(lk_mesi[w*2 +: 2]);
    end

    case (state_q)
      ST_IDLE: if (snoop_valid) begin
        state_d = ST_LOOKUP;
        line_d  = snoop_addr[31:NB_OFFSET];
        op_d    = snoop_op;
      end
      ST_LOOKUP: state_d = ST_COMPARE;
      ST_COMPARE: begin
        // Result and follow-up plan are decided here so RESULT can drive them from flops.
        state_d = ST_RESULT;
        way_d   = m_way;
        err_c   = m_multi;
        getl_d  = 1'b0;
        invl_d  = 1'b0;
        upd_d   = 1'b0;
        tgt_d   = MESI_I;
        case (op_q)
          OP_READ: if (m_hit) begin
            res_c  = (hmesi == MESI_M) ? SNP_HITM : SNP_HIT;
            getl_d = (hmesi == MESI_M);
            upd_d  = (hmesi == MESI_M) || (hmesi == MESI_E);
            tgt_d  = MESI_S;
          end
          OP_RWIM: if (m_hit) begin
            res_c  = (hmesi == MESI_M) ? SNP_HITM : SNP_HIT;
            getl_d = (hmesi == MESI_M);
            invl_d = 1'b1;
            upd_d  = 1'b1;
          end
          OP_INVALIDATE: if (m_hit) begin
            res_c  = SNP_HIT;
            err_c  = m_multi || (hmesi != MESI_S);
            invl_d = 1'b1;
            upd_d  = 1'b1;
          end
          OP_WRITE: err_c = m_multi || (m_hit && (hmesi == MESI_M));
          default:  err_c = 1'b1;
        endcase
      end
      ST_RESULT: state_d = getl_q ? ST_GETL : invl_q ? ST_INVL : upd_q ? ST_UPDATE : ST_IDLE;
      ST_GETL:   if (l1_msg_ready) state_d = ST_WB;
      ST_WB:     if (wb_ready) state_d = invl_q ? ST_INVL : ST_UPDATE;
      ST_INVL:   if (l1_msg_ready) state_d = ST_UPDATE;
      default:   state_d = ST_IDLE;
    endcase

    snoop_ready_d      = (state_d == ST_IDLE);
    lk_req_d           = (state_d == ST_LOOKUP);
    lk_index_d         = lk_req_d ? snoop_addr[NB_OFFSET +: NB_INDEX] : '0;
    snp_result_valid_d = (state_d == ST_RESULT);
    snp_result_d       = res_c;
    protocol_err_d     = err_c;
    st_we_d            = (state_d == ST_UPDATE);
    st_index_d         = st_we_d ? line_q[NB_INDEX-1:0] : '0;
    st_way_d           = st_we_d ? way_q : '0;
    st_mesi_d          = st_we_d ? tgt_q : MESI_I;
    l1_msg_valid_d     = (state_d == ST_GETL) || (state_d == ST_INVL);
    l1_msg_d           = (state_d == ST_GETL) ? MSG_GETLINE :
                         (state_d == ST_INVL) ? MSG_INVALIDATELINE : 3'd0;
    l1_msg_addr_d      = l1_msg_valid_d ? {line_q, {NB_OFFSET{1'b0}}} : 32'd0;
    wb_valid_d         = (state_d == ST_WB);
    wb_addr_d          = wb_valid_d ? {line_q, {NB_OFFSET{1'b0}}} : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      line_q             <= '0;
      op_q               <= '0;
      way_q              <= '0;
      tgt_q              <= MESI_I;
      getl_q             <= 1'b0;
      invl_q             <= 1'b0;
      upd_q              <= 1'b0;
      snoop_ready_q      <= 1'b1;
      lk_req_q           <= 1'b0;
      lk_index_q         <= '0;
      snp_result_valid_q <= 1'b0;
      snp_result_q       <= '0;
      protocol_err_q     <= 1'b0;
      st_we_q            <= 1'b0;
      st_index_q         <= '0;
      st_way_q           <= '0;
      st_mesi_q          <= '0;
      l1_msg_valid_q     <= 1'b0;
      l1_msg_q           <= '0;
      l1_msg_addr_q      <= '0;
      wb_valid_q         <= 1'b0;
      wb_addr_q          <= '0;
    end else begin
      state_q            <= state_d;
      line_q             <= line_d;
      op_q               <= op_d;
      way_q              <= way_d;
      tgt_q              <= tgt_d;
      getl_q             <= getl_d;
      invl_q             <= invl_d;
      upd_q              <= upd_d;
      snoop_ready_q      <= snoop_ready_d;
      lk_req_q           <= lk_req_d;
      lk_index_q         <= lk_index_d;
      snp_result_valid_q <= snp_result_valid_d;
      snp_result_q       <= snp_result_d;
      protocol_err_q     <= protocol_err_d;
      st_we_q            <= st_we_d;
      st_index_q         <= st_index_d;
      st_way_q           <= st_way_d;
      st_mesi_q          <= st_mesi_d;
      l1_msg_valid_q     <= l1_msg_valid_d;
      l1_msg_q           <= l1_msg_d;
      l1_msg_addr_q      <= l1_msg_addr_d;
      wb_valid_q         <= wb_valid_d;
      wb_addr_q          <= wb_addr_d;
    end
  end

  assign snoop_ready      = snoop_ready_q;
  assign lk_req           = lk_req_q;
  assign lk_index         = lk_index_q;
  assign snp_result_valid = snp_result_valid_q;
  assign snp_result       = snp_result_q;
  assign protocol_err     = protocol_err_q;
  assign st_we            = st_we_q;
  assign st_index         = st_index_q;
  assign st_way           = st_way_q;
  assign st_mesi          = st_mesi_q;
  assign l1_msg_valid     = l1_msg_valid_q;
  assign l1_msg           = l1_msg_q;
  assign l1_msg_addr      = l1_msg_addr_q;
  assign wb_valid         = wb_valid_q;
  assign wb_addr          = wb_addr_q;

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder: miss, E/M/S hits, handshake stalls, errors, reset mid-op.
module tb_snoop_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic snoop_valid, snoop_ready;
  logic [2:0] snoop_op;
  logic [31:0] snoop_addr;
  logic lk_req;
  logic [14:0] lk_index;
  logic [87:0] lk_tags;
  logic [15:0] lk_mesi;
  logic snp_result_valid;
  logic [1:0] snp_result;
  logic st_we;
  logic [14:0] st_index;
  logic [2:0] st_way;
  logic [1:0] st_mesi;
  logic l1_msg_valid;
  logic [2:0] l1_msg;
  logic [31:0] l1_msg_addr;
  logic l1_msg_ready;
  logic wb_valid;
  logic [31:0] wb_addr;
  logic wb_ready;
  logic protocol_err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] ADDR = 32'h1234_5680;

  snoop_responder dut (
    .clk(clk), .rst_n(rst_n),
    .snoop_valid(snoop_valid), .snoop_ready(snoop_ready), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .lk_req(lk_req), .lk_index(lk_index), .lk_tags(lk_tags), .lk_mesi(lk_mesi),
    .snp_result_valid(snp_result_valid), .snp_result(snp_result),
    .st_we(st_we), .st_index(st_index), .st_way(st_way), .st_mesi(st_mesi),
    .l1_msg_valid(l1_msg_valid), .l1_msg(l1_msg), .l1_msg_addr(l1_msg_addr), .l1_msg_ready(l1_msg_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {snoop_ready, lk_req, snp_result_valid, st_we, l1_msg_valid, wb_valid, protocol_err}
  function automatic logic [31:0] ctl();
    return {25'd0, snoop_ready, lk_req, snp_result_valid, st_we, l1_msg_valid, wb_valid, protocol_err};
  endfunction

  task automatic clear_ways;
    lk_tags = '0;
    lk_mesi = '0;
  endtask

  task automatic set_way(input int w, input logic [10:0] tag, input logic [1:0] st);
    lk_tags[w*11 +: 11] = tag;
    lk_mesi[w*2 +: 2]   = st;
  endtask

  // Accept, LOOKUP, COMPARE, ending at the RESULT cycle (accept + 3).
  task automatic issue(input string tag, input logic [2:0] op);
    chk({tag, "_ready"}, snoop_ready, 1);
    snoop_op    = op;
    snoop_addr  = ADDR;
    snoop_valid = 1'b1;
    tick;
    snoop_valid = 1'b0;
    snoop_addr  = '0;
    chk({tag, "_lkreq"}, lk_req, 1);
    chk({tag, "_lkidx"}, lk_index, 15'h515A);
    tick;
    chk({tag, "_noresult_early"}, snp_result_valid, 0);
    tick;
    chk({tag, "_resvld"}, snp_result_valid, 1);
  endtask

  initial begin
    rst_n = 1'b0; snoop_valid = 1'b0; snoop_op = '0; snoop_addr = '0;
    l1_msg_ready = 1'b0; wb_ready = 1'b0;
    clear_ways;
    tick; tick;
    chk("reset_ctl", ctl(), 32'b1000000);
    chk("reset_l1addr", l1_msg_addr, 0);
    rst_n = 1'b1;
    tick;

    // Miss: matching tag but Invalid must not hit.
    set_way(3, 11'h091, 2'd0);
    set_way(4, 11'h092, 2'd1);
    issue("miss", 3'd1);
    chk("miss_res", snp_result, 0);
    chk("miss_err", protocol_err, 0);
    tick;
    chk("miss_idle", ctl(), 32'b1000000);

    // Exclusive read -> S on way 5.
    clear_ways; set_way(5, 11'h091, 2'd2);
    issue("rdE", 3'd1);
    chk("rdE_res", snp_result, 1);
    tick;
    chk("rdE_ctl", ctl(), 32'b0001000);
    chk("rdE_idx", st_index, 15'h515A);
    chk("rdE_way", st_way, 5);
    chk("rdE_mesi", st_mesi, 1);
    tick;
    chk("rdE_idle", ctl(), 32'b1000000);

    // Modified RWIM with L1 stalled three cycles.
    clear_ways; set_way(2, 11'h091, 2'd3);
    issue("rwimM", 3'd4);
    chk("rwimM_res", snp_result, 2);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("rwimM_getl_vld", l1_msg_valid, 1);
      chk("rwimM_getl_msg", l1_msg, 2);
      chk("rwimM_getl_addr", l1_msg_addr, ADDR);
      if (i < 3) tick;
    end
    l1_msg_ready = 1'b1; wb_ready = 1'b1;
    tick;
    chk("rwimM_wb_ctl", ctl(), 32'b0000010);
    chk("rwimM_wb_addr", wb_addr, ADDR);
    tick;
    chk("rwimM_invl_vld", l1_msg_valid, 1);
    chk("rwimM_invl_msg", l1_msg, 3);
    tick;
    chk("rwimM_upd_we", st_we, 1);
    chk("rwimM_upd_way", st_way, 2);
    chk("rwimM_upd_mesi", st_mesi, 0);
    tick;
    chk("rwimM_idle", ctl(), 32'b1000000);

    // Invalidate on a shared line.
    clear_ways; set_way(0, 11'h091, 2'd1);
    issue("invS", 3'd3);
    chk("invS_res", snp_result, 1);
    chk("invS_err", protocol_err, 0);
    tick;
    chk("invS_msg", l1_msg, 3);
    chk("invS_addr", l1_msg_addr, ADDR);
    tick;
    chk("invS_we", st_we, 1);
    chk("invS_mesi", st_mesi, 0);
    chk("invS_way", st_way, 0);
    tick;

    // Illegal op code.
    issue("op6", 3'd6);
    chk("op6_res", snp_result, 0);
    chk("op6_err", protocol_err, 1);
    tick;
    chk("op6_idle", ctl(), 32'b1000000);

    // WRITE snooping a modified line.
    clear_ways; set_way(2, 11'h091, 2'd3);
    issue("wrM", 3'd2);
    chk("wrM_res", snp_result, 0);
    chk("wrM_err", protocol_err, 1);
    tick;
    chk("wrM_idle", ctl(), 32'b1000000);

    // Two ways hit: lowest (way 1) is used.
    clear_ways; set_way(6, 11'h091, 2'd1); set_way(1, 11'h091, 2'd1);
    issue("multi", 3'd3);
    chk("multi_res", snp_result, 1);
    chk("multi_err", protocol_err, 1);
    tick;
    chk("multi_err_pulse", protocol_err, 0);
    tick;
    chk("multi_we", st_we, 1);
    chk("multi_way", st_way, 1);
    tick;

    // Reset while a write-back is stalled.
    clear_ways; set_way(2, 11'h091, 2'd3);
    l1_msg_ready = 1'b1; wb_ready = 1'b0;
    issue("rst", 3'd4);
    tick; tick;
    chk("rst_wb_vld", wb_valid, 1);
    rst_n = 1'b0;
    tick;
    chk("rst_ctl", ctl(), 32'b1000000);
    chk("rst_wbaddr", wb_addr, 0);
    chk("rst_stmesi", st_mesi, 0);
    rst_n = 1'b1;
    tick;
    chk("rst_after_ctl", ctl(), 32'b1000000);
    tick;
    chk("rst_no_we", st_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
- Responder side of the shared-bus snoop protocol. Accepts one bus operation (READ/WRITE/INVALIDATE/RWIM) issued by another cache.
- Looks the address up in the L2 tag/MESI store and returns the snoop result (NOHIT/HIT/HITM).
- Sequences the follow-up actions: L2-to-L1 message, write-back of a modified line, MESI state update.
- Sits between the bus snoop interface and the L2 tag/state arrays. Owns no arrays itself.

Parameters:
- WAYS, 8, associativity.
- NB_OFFSET, 6, byte-offset bits, addr[5:0].
- NB_INDEX, 15, set-index bits, addr[20:6].
- NB_TAG, 11, tag bits, addr[31:21].

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- snoop_valid  in  1  bus op presented.
- snoop_ready  out  1  responder idle, op accepted when valid&&ready.
- snoop_op  in  3  bus op code; 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM.
- snoop_addr  in  32  snooped address.
- lk_req  out  1  tag/state lookup strobe.
- lk_index  out  NB_INDEX  set to read.
- lk_tags  in  WAYS*NB_TAG  way tags; way w at [w*NB_TAG +: NB_TAG].
- lk_mesi  in  WAYS*2  way MESI states; way w at [w*2 +: 2].
- snp_result_valid  out  1  one-cycle pulse.
- snp_result  out  2  0 NOHIT, 1 HIT, 2 HITM.
- st_we  out  1  state write strobe.
- st_index  out  NB_INDEX  set to update.
- st_way  out  $clog2(WAYS)  way to update.
- st_mesi  out  2  new state.
- l1_msg_valid  out  1  message to L1 pending.
- l1_msg  out  3  2 GETLINE, 3 INVALIDATELINE.
- l1_msg_addr  out  32  line address, offset bits zero.
- l1_msg_ready  in  1  L1 accepts.
- wb_valid  out  1  write-back of modified line pending.
- wb_addr  out  32  line address, offset bits zero.
- wb_ready  in  1  bus accepts write-back.
- protocol_err  out  1  one-cycle pulse on an illegal condition.

Behaviour:
- Reset: synchronous on rst_n=0 at a clk edge. FSM goes to IDLE. snoop_ready=1; every other output 0. An in-flight op is dropped with no state write.
- FSM states: IDLE, LOOKUP, COMPARE, RESULT, GETL, WB, INVL, UPDATE.
- IDLE: snoop_ready=1. On accept, register op and address, then go to LOOKUP.
- LOOKUP: lk_req=1 and lk_index=index for one cycle. The array returns lk_tags/lk_mesi exactly one cycle later. Go to COMPARE.
- COMPARE: a way hits when its tag matches and its MESI state is not I. Register hit, way and MESI state. Go to RESULT.
- Multiple hitting ways: pulse protocol_err and use the lowest way.
- RESULT: drive snp_result_valid=1 for one cycle. Result and next action by op and hit state:
  - READ, M: HITM; GETL, then WB, then UPDATE to S.
  - READ, E: HIT; UPDATE to S.
  - READ, S: HIT; IDLE.
  - RWIM, M: HITM; GETL, then WB, then INVL, then UPDATE to I.
  - RWIM, E or S: HIT; INVL, then UPDATE to I.
  - INVALIDATE, S: HIT; INVL, then UPDATE to I.
  - INVALIDATE, E or M: HIT; pulse protocol_err; INVL, then UPDATE to I.
  - WRITE: NOHIT; IDLE. If the line is M, also pulse protocol_err.
  - Miss, any op: NOHIT; IDLE.
  - Op code 0 or 5–7: NOHIT; pulse protocol_err; IDLE.
- GETL and INVL: hold l1_msg_valid with stable l1_msg and l1_msg_addr until l1_msg_ready. Advance on the cycle valid&&ready.
- WB: same hold rule using wb_valid/wb_ready.
- No timeout on any handshake; a stalled handshake stalls the block indefinitely.
- UPDATE: st_we=1 for one cycle with st_index, st_way, st_mesi. Go to IDLE.
- A new op cannot be accepted in the same cycle as UPDATE.
- Minimum op-to-op spacing: 4 cycles (miss path: accept, LOOKUP, COMPARE, RESULT, then IDLE).
- Result latency: accept at cycle N gives snp_result_valid at N+3.

Decomposition:
- Shared package cache_Defs:
  - add mesi_t enum: I=0, S=1, E=2, M=3.
  - add the FSM state enum.
  - reuse the existing bus-op, snoop-result and L2-to-L1 message constants, with address field widths as constants.
- Sub-module snoop_way_match: combinational comparison of WAYS tags and states. Outputs hit, one-hot vector, encoded lowest way and multi_hit.

Test Plan:
- Miss: READ 0x12345680 (index 0x515A, tag 0x091), no way matches → snp_result=NOHIT at N+3; no st_we, no l1_msg, no wb_valid.
- Exclusive read: READ 0x12345680 with way 5 tag 0x091 in state E → HIT; st_we with st_way=5, st_mesi=S; no L1 message.
- Modified RWIM: RWIM to the same line, way 2 in state M, l1_msg_ready held low 3 cycles → HITM; GETLINE held stable 3 cycles; then wb_valid with wb_addr 0x12345680; then INVALIDATELINE; st_mesi=I on way 2.
- Invalidate shared: INVALIDATE, way 0 in state S → HIT; INVALIDATELINE with l1_msg_addr 0x12345680; st_mesi=I.
- Errors: op code 6 → NOHIT plus protocol_err pulse. Two ways matching tag 0x091 → lowest way used, protocol_err pulse.
- Reset mid-op: rst_n low during WB → next cycle all outputs 0, snoop_ready=1, no st_we.
